// File: rtl/gbf_sched_pkg.sv
// Shared definitions for the GBF port schedulers (input-side and weight-side).
//   sched_state_t : scheduler FSM encoding
//   tile_base()   : tile index -> GBF base word address, reduced mod the buffer depth
package gbf_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST, S_DRAIN} sched_state_t;

  // Wide enough for IDX_W*2 + $clog2(BURST_LEN) bits of intermediate product at any
  // practical parameterisation, so the modulo sees the full value.
  localparam int CALC_W = 64;

  function automatic logic [CALC_W-1:0] tile_base(
    input logic [CALC_W-1:0] i,
    input logic [CALC_W-1:0] k,
    input logic [CALC_W-1:0] kdim,
    input logic [CALC_W-1:0] burst_len,
    input logic [CALC_W-1:0] height
  );
    logic [CALC_W-1:0] tile;
    tile = i * kdim + k;
    return (tile * burst_len) % height;
  endfunction

endpackage

// File: rtl/gbf_port_scheduler_rr_pick.sv
// rr_pick: combinational circular first-one search.
//   cand   : candidate request vector
//   ptr    : search starts at this index and wraps around
//   onehot : one-hot of the selected candidate (zero when none)
//   bin    : binary index of the selected candidate
//   valid  : at least one candidate was set
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] bin,
  output logic         valid
);

  always_comb begin
    logic [W-1:0] idx;
    onehot = '0;
    bin    = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = W'((32'(ptr) + off) % N);
      if (!valid && cand[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
        bin         = idx;
      end
    end
  end

endmodule

// File: rtl/gbf_port_scheduler.sv
// gbf_port_scheduler: sequences one GBF read port shared by NUM_REQ PEs.
// After start, pending requests within the latched mask are granted round-robin,
// one BURST_LEN-word tile burst each; done pulses once every masked PE is served.
//   clk, rst            : clock, asynchronous active-low reset
//   start, active_mask  : begin a round; mask of PEs to serve (sampled on start)
//   req, i_idx, k_idx   : per-PE requests and packed tile indices
//   grant, sel          : one-hot / binary granted PE (held through the drain cycle)
//   addr, addr_valid    : GBF read address and beat strobe
//   data_valid          : addr_valid delayed by the RAM read latency
//   burst_done, busy, done : end-of-burst pulse, not-idle flag, end-of-round pulse
// Build option SCHED_PERF_CNT_EN adds perf_bursts / perf_wait saturating counters.
module gbf_port_scheduler
  import gbf_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 8,
  parameter int KDIM      = 3,
  parameter int BURST_LEN = 16,
  parameter int HEIGHT    = 96,
  parameter int ADDR_W    = $clog2(HEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_REQ-1:0]         active_mask,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*IDX_W-1:0]   i_idx,
  input  logic [NUM_REQ*IDX_W-1:0]   k_idx,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic [ADDR_W-1:0]          addr,
  output logic                       addr_valid,
  output logic                       data_valid,
  output logic                       burst_done,
  output logic                       busy,
  output logic                       done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]                perf_bursts,
  output logic [15:0]                perf_wait
`endif
);

  localparam int SEL_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  sched_state_t       state;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] served;
  logic [SEL_W-1:0]   rr_ptr;
  logic [BEAT_W-1:0]  beat;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [SEL_W-1:0]   pick_bin;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_i;
  logic [IDX_W-1:0]   pick_k;
  logic [ADDR_W-1:0]  pick_base;
  logic [SEL_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  addr_next;
  logic               last_beat;

  assign cand = req & mask & ~served;

  rr_pick #(.N(NUM_REQ), .W(SEL_W)) u_pick (
    .cand   (cand),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .bin    (pick_bin),
    .valid  (pick_valid)
  );

  assign pick_i    = i_idx[pick_bin*IDX_W +: IDX_W];
  assign pick_k    = k_idx[pick_bin*IDX_W +: IDX_W];
  assign pick_base = ADDR_W'(tile_base(64'(pick_i), 64'(pick_k), 64'(KDIM),
                                       64'(BURST_LEN), 64'(HEIGHT)));

  assign next_ptr  = (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
  assign addr_next = (addr == ADDR_W'(HEIGHT - 1)) ? '0 : addr + ADDR_W'(1);
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mask       <= '0;
      served     <= '0;
      rr_ptr     <= '0;
      beat       <= '0;
      grant      <= '0;
      sel        <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      burst_done <= 1'b0;
      data_valid <= addr_valid;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask   <= active_mask;
            served <= '0;
            if (active_mask == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (pick_valid) begin
            grant      <= pick_onehot;
            sel        <= pick_bin;
            addr       <= pick_base;
            addr_valid <= 1'b1;
            beat       <= '0;
            state      <= S_BURST;
          end
        end
        S_BURST: begin
          if (!req[sel]) begin
            // Abort: the PE is skipped this pass and stays unserved.
            addr_valid <= 1'b0;
            grant      <= '0;
            rr_ptr     <= next_ptr;
            state      <= S_ARB;
          end else if (last_beat) begin
            addr_valid <= 1'b0;
            burst_done <= 1'b1;
            state      <= S_DRAIN;
          end else begin
            addr <= addr_next;
            beat <= beat + BEAT_W'(1);
          end
        end
        S_DRAIN: begin
          served <= served | grant;
          rr_ptr <= next_ptr;
          grant  <= '0;
          if ((served | grant) == mask) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_ARB;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // In ARB a non-empty cand is granted in that same cycle, so it never counts as waiting.
  logic wait_cycle;
  assign wait_cycle = (|cand) && !(|grant) && (state != S_ARB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bursts <= '0;
      perf_wait   <= '0;
    end else if (state == S_IDLE && start) begin
      perf_bursts <= '0;
      perf_wait   <= '0;
    end else begin
      if (state == S_DRAIN && perf_bursts != '1) perf_bursts <= perf_bursts + 16'd1;
      if (wait_cycle && perf_wait != '1)         perf_wait   <= perf_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gbf_port_scheduler.sv
// Self-checking bench for gbf_port_scheduler: table of scheduling rounds plus
// hand-written abort and mid-burst reset sequences, with a beat scoreboard.
module tb_gbf_port_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  active_mask = '0;
  logic [3:0]  req = '0;
  logic [31:0] i_idx = '0;
  logic [31:0] k_idx = '0;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [6:0]  addr;
  logic        addr_valid, data_valid, burst_done, busy, done;
`ifdef SCHED_PERF_CNT_EN
  logic [15:0] perf_bursts, perf_wait;
`endif

  gbf_port_scheduler #(
    .NUM_REQ(4), .IDX_W(8), .KDIM(3), .BURST_LEN(16), .HEIGHT(96), .ADDR_W(7)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .active_mask(active_mask), .req(req),
    .i_idx(i_idx), .k_idx(k_idx), .grant(grant), .sel(sel), .addr(addr),
    .addr_valid(addr_valid), .data_valid(data_valid), .burst_done(burst_done),
    .busy(busy), .done(done)
`ifdef SCHED_PERF_CNT_EN
    , .perf_bursts(perf_bursts), .perf_wait(perf_wait)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] pe;
    logic [6:0] addr;
  } beat_t;

  beat_t      beat_q[$];
  logic [1:0] bd_q[$];

  task automatic push_burst(input logic [1:0] pe, input int unsigned i, input int unsigned k,
                            input int unsigned nbeats);
    int unsigned a;
    a = ((i * 3 + k) * 16) % 96;
    for (int unsigned b = 0; b < nbeats; b++) begin
      beat_q.push_back({pe, 7'(a)});
      a = (a == 95) ? 0 : a + 1;
    end
  endtask

  // Scoreboard: every live beat and burst_done is matched against the expectation queues.
  always @(negedge clk) begin
    beat_t      e;
    logic [1:0] p;
    if (mon_en && rst) begin
      if (addr_valid) begin
        if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = beat_q.pop_front();
          check("beat_sel", sel, e.pe);
          check("beat_grant", grant, 4'b0001 << e.pe);
          check("beat_addr", addr, e.addr);
        end
      end
      if (burst_done) begin
        if (bd_q.size() == 0) check("unexpected_burst_done", 1, 0);
        else begin
          p = bd_q.pop_front();
          check("burst_done_sel", sel, p);
          check("burst_done_data_valid", data_valid, 1);
          check("burst_done_no_addr", addr_valid, 0);
        end
      end
    end
  end

  // Caller is positioned just after a negedge. Counts cycles from the start edge.
  task automatic run_round(input int unsigned exp_done, input logic chk_lat,
                           input int unsigned restart_at, input int abort_pe,
                           input int unsigned abort_beats, input int restore_pe);
    int unsigned s0, cnt, got, first_av, first_dv, pe_beats;
    bit seen, dropped;
    s0 = cyc; seen = 1'b0; dropped = 1'b0; got = 0;
    first_av = 0; first_dv = 0; pe_beats = 0;
    start = 1'b1;
    for (int unsigned n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      cnt = cyc - s0;
      if (addr_valid && first_av == 0) first_av = cnt;
      if (data_valid && first_dv == 0) first_dv = cnt;
      if (cnt == 1 && exp_done > 1) check("busy_after_start", busy, 1);
`ifdef SCHED_PERF_CNT_EN
      if (cnt == 1) check("perf_cleared_by_start", {perf_bursts, perf_wait}, 0);
`endif
      if (restart_at != 0 && cnt == restart_at) start = 1'b1;
      if (abort_pe >= 0 && !dropped && addr_valid && grant[abort_pe[1:0]]) begin
        pe_beats++;
        if (pe_beats == abort_beats) begin
          req[abort_pe[1:0]] = 1'b0;
          dropped = 1'b1;
        end
      end
      if (dropped && restore_pe >= 0 && grant[restore_pe[1:0]]) req[abort_pe[1:0]] = 1'b1;
      if (done) begin
        seen = 1'b1;
        got  = cnt;
        check("idle_at_done", busy, 0);
      end
    end
    check("done_seen", seen, 1);
    check("done_cycle", got, exp_done);
    if (chk_lat) begin
      check("first_addr_latency", first_av, 2);
      check("first_data_latency", first_dv, 3);
    end
    check("beats_consumed", beat_q.size(), 0);
    check("bursts_consumed", bd_q.size(), 0);
  endtask

  typedef struct packed {
    logic [3:0]  mask;
    logic [3:0]  req;
    logic [31:0] i_vec;
    logic [31:0] k_vec;
    logic [2:0]  n_bursts;
    logic [7:0]  order;     // granted PE of burst b at [2*b +: 2]
    logic [15:0] done_cyc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // Round-robin pointer carries across rounds; orders below account for it.
    vecs[0] = '{4'hF, 4'hF, 32'h00000000, 32'h03020100, 3'd4, 8'hE4, 16'd73}; // bases 0,16,32,48
    vecs[1] = '{4'h5, 4'hF, 32'h00020001, 32'h00000002, 3'd2, 8'h08, 16'd37}; // tile5->80, tile6->0
    vecs[2] = '{4'h6, 4'hF, 32'h00030000, 32'h00000500, 3'd2, 8'h09, 16'd37}; // ptr 3 wraps to PE1
    vecs[3] = '{4'h8, 4'hF, 32'h0A000000, 32'h01000000, 3'd1, 8'h03, 16'd19}; // tile31 -> 16
    vecs[4] = '{4'h0, 4'hF, 32'h00000000, 32'h00000000, 3'd0, 8'h00, 16'd1};  // empty mask
    vecs[5] = '{4'h1, 4'hF, 32'h000000FF, 32'h000000FE, 3'd1, 8'h00, 16'd19}; // tile1019 -> 80

    repeat (3) @(negedge clk);
    check("reset_outputs", {grant, sel, addr, addr_valid, data_valid, burst_done, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {grant, addr_valid, busy, done}, 0);

    for (int unsigned v = 0; v < 6; v++) begin
      active_mask = vecs[v].mask;
      req         = vecs[v].req;
      i_idx       = vecs[v].i_vec;
      k_idx       = vecs[v].k_vec;
      for (int unsigned b = 0; b < vecs[v].n_bursts; b++) begin
        logic [1:0] pe;
        pe = vecs[v].order[2*b +: 2];
        push_burst(pe, int'(vecs[v].i_vec[pe*8 +: 8]), int'(vecs[v].k_vec[pe*8 +: 8]), 16);
        bd_q.push_back(pe);
      end
      run_round(int'(vecs[v].done_cyc), vecs[v].n_bursts != 0, (v == 1) ? 20 : 0, -1, 0, -1);
`ifdef SCHED_PERF_CNT_EN
      if (v == 0) begin
        check("perf_bursts", perf_bursts, 4);
        check("perf_wait", perf_wait, 0);
      end
`endif
    end

    // Abort: pointer sits at 1. PE1 drops req after 6 beats, PE2/PE3/PE0 follow, then PE1.
    active_mask = 4'hF;
    req         = 4'hF;
    i_idx       = 32'h00000000;
    k_idx       = 32'h03020100;
    push_burst(2'd1, 0, 1, 6);
    push_burst(2'd2, 0, 2, 16); bd_q.push_back(2'd2);
    push_burst(2'd3, 0, 3, 16); bd_q.push_back(2'd3);
    push_burst(2'd0, 0, 0, 16); bd_q.push_back(2'd0);
    push_burst(2'd1, 0, 1, 16); bd_q.push_back(2'd1);
    run_round(80, 1'b1, 0, 1, 6, 2);

    // Reset in the middle of a burst (after beat 7).
    begin
      int unsigned nb;
      bit hit;
      nb = 0; hit = 1'b0;
      mon_en = 1'b0;
      start = 1'b1;
      for (int unsigned n = 0; n < 60 && !hit; n++) begin
        @(negedge clk);
        start = 1'b0;
        if (addr_valid) nb++;
        if (nb == 8) hit = 1'b1;
      end
      check("reset_point_reached", hit, 1);
      rst = 1'b0;
      #1;
      check("mid_burst_reset_outputs",
            {grant, sel, addr, addr_valid, data_valid, burst_done, busy, done}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      beat_q.delete();
      bd_q.delete();
      for (int unsigned n = 0; n < 10; n++) begin
        @(negedge clk);
        check("no_grant_without_start", {grant, addr_valid, busy, burst_done, done}, 0);
      end
      mon_en = 1'b1;
    end

    // After reset the pointer is back at 0 and a fresh start is needed.
    active_mask = 4'h3;
    push_burst(2'd0, 0, 0, 16); bd_q.push_back(2'd0);
    push_burst(2'd1, 0, 1, 16); bd_q.push_back(2'd1);
    run_round(37, 1'b1, 0, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
